// File: rtl/parity_seq_ctrl_if.sv
// Word-in / parity-out handshake bundle for parity_seq_ctrl.
// The master drives words and out_ready; the slave (the block) returns in_ready and the result.
interface parity_seq_ctrl_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic [W-1:0] in_word;
    logic         in_ready;
    logic         out_valid;
    logic         out_parity;
    logic         out_ready;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_parity
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_parity
    );
endinterface

// File: rtl/parity_seq_ctrl.sv
// Nibble-serial parity reducer: one nibble per cycle through an external 4-input XOR. Optional PARITY_CHECK_EN adds exp_par/par_err.
// Latency: result valid NIBBLES cycles after the accepting edge.
// Backpressure: the result is held in DONE until out_ready; no new word is accepted before returning to IDLE.
module parity_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    parity_seq_ctrl_if.slave     bus,
    output logic                 busy,
    output logic                 nib_a,
    output logic                 nib_b,
    output logic                 nib_c,
    output logic                 nib_d,
    input  logic                 nib_x
`ifdef PARITY_CHECK_EN
    ,
    input  logic                 exp_par,
    output logic                 par_err
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    word_q, word_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      nib;
`ifdef PARITY_CHECK_EN
    logic            exp_q, exp_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef PARITY_CHECK_EN
            exp_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef PARITY_CHECK_EN
            exp_q   <= exp_d;
`endif
        end
    end

    // Nibble mux: only the selected nibble is presented, and only while shifting.
    always_comb begin
        nib = 4'h0;
        if (state_q == S_SHIFT) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (cnt_q == CW'(i)) begin
                    nib = word_q[4*i +: 4];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
`ifdef PARITY_CHECK_EN
        exp_d   = exp_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    word_d  = bus.in_word;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
`ifdef PARITY_CHECK_EN
                    exp_d   = exp_par;
`endif
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = acc_q ^ nib_x;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_parity = (state_q == S_DONE) & acc_q;
    assign busy           = (state_q != S_IDLE);
    assign nib_a          = nib[0];
    assign nib_b          = nib[1];
    assign nib_c          = nib[2];
    assign nib_d          = nib[3];
`ifdef PARITY_CHECK_EN
    assign par_err        = (state_q == S_DONE) & (acc_q ^ exp_q);
`endif
endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Bench for parity_seq_ctrl (NIBBLES=4): timeline model checked every cycle plus literal expectations.
module tb_parity_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    logic rst;
    logic busy, nib_a, nib_b, nib_c, nib_d, nib_x;
`ifdef PARITY_CHECK_EN
    logic exp_par, par_err;
`endif

    always #5 clk = ~clk;

    parity_seq_ctrl_if #(.W(W)) bus ();

    assign nib_x = nib_a ^ nib_b ^ nib_c ^ nib_d;

    parity_seq_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .busy  (busy),
        .nib_a (nib_a),
        .nib_b (nib_b),
        .nib_c (nib_c),
        .nib_d (nib_d),
        .nib_x (nib_x)
`ifdef PARITY_CHECK_EN
        ,
        .exp_par (exp_par),
        .par_err (par_err)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int edge_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk) edge_cnt++;

    // Model: a word is either absent, or at some age since acceptance.
    // Ages 0..N-1 present nibble[age]; from age N the result waits for out_ready.
    bit           m_have = 1'b0;
    int           m_age  = 0;
    logic [W-1:0] m_word = '0;
    bit           m_exp  = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic       e_rdy, e_ov, e_par, e_busy;
            logic [3:0] e_nib;
            e_rdy = !m_have;
            e_busy = m_have;
            e_ov = m_have && (m_age >= N);
            e_par = e_ov ? ^m_word : 1'b0;
            e_nib = (m_have && m_age < N) ? 4'(m_word >> (4 * m_age)) : 4'h0;
            chk("in_ready",   {31'd0, bus.in_ready},   {31'd0, e_rdy});
            chk("out_valid",  {31'd0, bus.out_valid},  {31'd0, e_ov});
            chk("out_parity", {31'd0, bus.out_parity}, {31'd0, e_par});
            chk("busy",       {31'd0, busy},           {31'd0, e_busy});
            chk("nibble",     {28'd0, nib_d, nib_c, nib_b, nib_a}, {28'd0, e_nib});
`ifdef PARITY_CHECK_EN
            chk("par_err", {31'd0, par_err}, {31'd0, e_ov & (e_par ^ m_exp)});
`endif
            if (rst) begin
                m_have = 1'b0;
            end else if (!m_have) begin
                if (bus.in_valid) begin
                    m_have = 1'b1;
                    m_age  = 0;
                    m_word = bus.in_word;
`ifdef PARITY_CHECK_EN
                    m_exp  = exp_par;
`endif
                end
            end else if (m_age >= N) begin
                if (bus.out_ready) m_have = 1'b0;
            end else begin
                m_age++;
            end
        end
    end

    task automatic send(input logic [W-1:0] w, input bit ex, output int acc_edge);
        bit ok = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_word  = w;
`ifdef PARITY_CHECK_EN
        exp_par = ex;
`else
        if (ex) ok = 1'b0;
`endif
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        acc_edge = edge_cnt;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(input int acc_edge, output bit p, output int lat);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) chk("result_timeout", 0, 1);
        p   = bus.out_parity;
        lat = edge_cnt - acc_edge;
    endtask

    logic [W-1:0] vec_w [4] = '{16'h0001, 16'hFFFF, 16'h8421, 16'h7000};
    bit           vec_p [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int ae, lat, hs;
        bit p;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        bus.out_ready = 1'b1;
`ifdef PARITY_CHECK_EN
        exp_par = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        @(posedge clk); #1 rst = 1'b0;

        send(16'h0000, 1'b0, ae);
        wait_result(ae, p, lat);
        chk("lat_0000", lat, N);
        chk("par_0000", {31'd0, p}, 0);

        for (int k = 0; k < 4; k++) begin
            send(vec_w[k], 1'b0, ae);
            wait_result(ae, p, lat);
            chk("lat_vec", lat, N);
            chk("par_vec", {31'd0, p}, {31'd0, vec_p[k]});
        end

        // Result held under backpressure while a new word is waiting.
        @(posedge clk); #1 bus.out_ready = 1'b0;
        send(16'h00F1, 1'b0, ae);
        wait_result(ae, p, lat);
        chk("par_bp", {31'd0, p}, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 1);
            chk("bp_hold_par", {31'd0, bus.out_parity}, 1);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 hs = edge_cnt;
        @(posedge clk); #1;
        ae = edge_cnt;
        bus.in_valid = 1'b0;
        chk("bp_accept_gap", ae - hs, 1);
        wait_result(ae, p, lat);
        chk("par_after_bp", {31'd0, p}, 0);

        // Reset during the second SHIFT cycle.
        send(16'h1111, 1'b0, ae);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 1);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        send(16'h0003, 1'b0, ae);
        wait_result(ae, p, lat);
        chk("par_0003", {31'd0, p}, 0);

`ifdef PARITY_CHECK_EN
        send(16'h0001, 1'b1, ae);
        wait_result(ae, p, lat);
        chk("par_err_match", {31'd0, par_err}, 0);
        send(16'h0001, 1'b0, ae);
        wait_result(ae, p, lat);
        chk("par_err_mismatch", {31'd0, par_err}, 1);
`endif

        @(posedge clk); #1;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
